// File: rtl/dmem_sized_pipe.sv
// dmem_sized_pipe
// Byte-addressed, little-endian data memory for the CPU MEM stage. It supports
// sized loads and stores (byte/half/word/double) with sign or zero extension on
// loads. Misaligned, out-of-range and illegal-size requests are flagged as
// errors. Requests and responses use a valid/ready handshake, and the response
// path is a pipeline of RD_LAT register stages that stalls as one unit under
// backpressure.
//
// Ports:
//   clk_i          clock
//   rst_i          asynchronous active-low reset (clears memory and pipe)
//   req_valid_i    request present
//   req_ready_o    request accepted when high together with req_valid_i
//   req_write_i    1 = store, 0 = load
//   req_size_i     0 byte, 1 half, 2 word, 3 double
//   req_unsigned_i 1 = zero-extend load, 0 = sign-extend
//   addr_i         byte address
//   data_i         store data (low 2^size bytes used)
//   rsp_valid_o    response present
//   rsp_ready_i    consumer takes the response
//   rsp_data_o     load result, 0 for stores and errors
//   rsp_err_o      misaligned / out of range / illegal size
module dmem_sized_pipe #(
   parameter int DATA_W      = 64,
   parameter int DEPTH_BYTES = 256,
   parameter int ADDR_W      = 64,
   parameter int RD_LAT      = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_write_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] data_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic              rsp_err_o
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = $clog2(DEPTH_BYTES);

   logic [7:0]        mem [DEPTH_BYTES];
   logic              st_valid [RD_LAT];
   logic              st_err [RD_LAT];
   logic [DATA_W-1:0] st_data [RD_LAT];

   logic              advance;
   logic              accept;
   logic              misaligned;
   logic              out_of_range;
   logic              bad_size;
   logic              req_err;
   logic [3:0]        size_bytes;
   logic [ADDR_W:0]   end_addr;
   logic [IDX_W-1:0]  base_idx;
   logic [DATA_W-1:0] raw_data;
   logic [DATA_W-1:0] load_data;
   logic              load_sign;
   int                load_bits;

   // The whole response pipe moves only when the output stage is empty or
   // being consumed; ready is forced low while reset is asserted.
   assign advance     = !rsp_valid_o || rsp_ready_i;
   assign req_ready_o = rst_i && advance;
   assign accept      = req_valid_i && req_ready_o;

   // The range check uses one extra bit so that a large address cannot wrap
   // back into range. Address bits above the memory index are included.
   assign size_bytes   = 4'd1 << req_size_i;
   assign end_addr     = {1'b0, addr_i} + {{(ADDR_W-3){1'b0}}, size_bytes};
   assign out_of_range = end_addr > (ADDR_W+1)'(DEPTH_BYTES);
   assign bad_size     = (req_size_i == 2'd3) && (DATA_W == 32);
   assign req_err      = misaligned || out_of_range || bad_size;
   assign base_idx     = addr_i[IDX_W-1:0];

   // Alignment only depends on the low address bits for the given size.
   always_comb begin
      misaligned = 1'b0;
      case (req_size_i)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = addr_i[0];
         2'd2:    misaligned = |addr_i[1:0];
         default: misaligned = |addr_i[2:0];
      endcase
   end

   // Gather a full data word of bytes starting at the address. The index may
   // wrap for erroneous requests, but their data is discarded anyway.
   always_comb begin
      raw_data = '0;
      for (int k = 0; k < NB; k++) begin
         raw_data[8*k +: 8] = mem[base_idx + IDX_W'(k)];
      end
   end

   // Keep the low 8<<size bits and fill the rest with the sign bit, or with
   // zero for unsigned loads. A full-width load has nothing to fill.
   always_comb begin
      load_bits = 8 << req_size_i;
      case (req_size_i)
         2'd0:    load_sign = raw_data[7];
         2'd1:    load_sign = raw_data[15];
         default: load_sign = raw_data[31];
      endcase
      load_sign = load_sign && !req_unsigned_i;
      load_data = '0;
      for (int b = 0; b < DATA_W; b++) begin
         load_data[b] = (b < load_bits) ? raw_data[b] : load_sign;
      end
   end

   // Byte storage. Only accepted, error-free stores write, and only the low
   // 2^size bytes of the store data are used. Reset wins over a coincident store.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH_BYTES; i++) begin
            mem[i] <= '0;
         end
      end else if (accept && req_write_i && !req_err) begin
         for (int k = 0; k < NB; k++) begin
            if (k < int'(size_bytes)) begin
               mem[base_idx + IDX_W'(k)] <= data_i[8*k +: 8];
            end
         end
      end
   end

   // Response pipeline. Stage 0 captures this cycle's request (or a bubble).
   // Every stage shifts together, so bubbles are kept while stalled.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < RD_LAT; i++) begin
            st_valid[i] <= 1'b0;
            st_err[i]   <= 1'b0;
            st_data[i]  <= '0;
         end
      end else if (advance) begin
         st_valid[0] <= accept;
         st_err[0]   <= accept && req_err;
         st_data[0]  <= (accept && !req_err && !req_write_i) ? load_data : '0;
         for (int i = 1; i < RD_LAT; i++) begin
            st_valid[i] <= st_valid[i-1];
            st_err[i]   <= st_err[i-1];
            st_data[i]  <= st_data[i-1];
         end
      end
   end

   assign rsp_valid_o = st_valid[RD_LAT-1];
   assign rsp_err_o   = st_err[RD_LAT-1];
   assign rsp_data_o  = st_data[RD_LAT-1];

endmodule

// File: tb/tb_dmem_sized_pipe.sv
// tb_dmem_sized_pipe
// Self-checking bench for dmem_sized_pipe. The main instance is 64-bit wide
// with a three-stage response pipe and is checked every cycle against a
// reference model. The model is a byte array plus a queue of expected
// responses, and it derives response timing from accept time and stall count.
// A second instance, 32-bit wide with single-cycle latency, gets a few
// directed checks.
`timescale 1ns/1ps
module tb_dmem_sized_pipe;

   localparam int LAT = 3;

   typedef struct {
      logic [63:0] data;
      logic        err;
      int          acc_cycle;
      int          acc_stalls;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        req_valid, req_ready, req_write, req_unsigned;
   logic [1:0]  req_size;
   logic [63:0] addr, wdata, rsp_data;
   logic        rsp_valid, rsp_ready, rsp_err;

   logic        req_valid_b, req_ready_b, req_write_b, req_unsigned_b;
   logic [1:0]  req_size_b;
   logic [63:0] addr_b;
   logic [31:0] wdata_b, rsp_data_b;
   logic        rsp_valid_b, rsp_ready_b, rsp_err_b;

   byte unsigned ref_mem [256];
   exp_t         exp_q[$];
   logic [63:0]  rsp_log[$];
   logic         err_log[$];
   int           checks = 0;
   int           errors = 0;
   int           cycle_no = 0;
   int           stall_no = 0;

   always #5 clk = ~clk;

   dmem_sized_pipe #(.DATA_W(64), .DEPTH_BYTES(256), .ADDR_W(64), .RD_LAT(LAT)) u_dut (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_write_i(req_write), .req_size_i(req_size), .req_unsigned_i(req_unsigned),
      .addr_i(addr), .data_i(wdata),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
      .rsp_data_o(rsp_data), .rsp_err_o(rsp_err)
   );

   dmem_sized_pipe #(.DATA_W(32), .DEPTH_BYTES(256), .ADDR_W(64), .RD_LAT(1)) u_dut_b (
      .clk_i(clk), .rst_i(rst_n),
      .req_valid_i(req_valid_b), .req_ready_o(req_ready_b),
      .req_write_i(req_write_b), .req_size_i(req_size_b), .req_unsigned_i(req_unsigned_b),
      .addr_i(addr_b), .data_i(wdata_b),
      .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b),
      .rsp_data_o(rsp_data_b), .rsp_err_o(rsp_err_b)
   );

   // One comparison: count it, and on mismatch count and report the failure.
   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference behaviour of one accepted request. Memory is updated for
   // legal stores, and the response the consumer should eventually see is
   // returned.
   task automatic refRequest(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [63:0] a, input logic [63:0] d, output exp_t e);
      int          nbytes;
      int          base;
      logic [64:0] end_addr;
      logic [63:0] val;
      nbytes   = 1 << sz;
      end_addr = {1'b0, a} + 65'(nbytes);
      e.err    = ((a % 64'(nbytes)) != 0) || (end_addr > 65'd256);
      e.data   = '0;
      if (!e.err) begin
         base = int'(a[7:0]);
         if (wr) begin
            for (int k = 0; k < nbytes; k++) ref_mem[base + k] = 8'(d >> (8*k));
         end else begin
            val = '0;
            for (int k = 0; k < nbytes; k++) val = val | (64'(ref_mem[base + k]) << (8*k));
            if (!uns && nbytes < 8 && ((val >> (8*nbytes - 1)) & 64'd1) != 0)
               val = val - (64'd1 << (8*nbytes));
            e.data = val;
         end
      end
   endtask

   // Drive one cycle on the main instance, called just after a falling edge.
   // Outputs are compared against the model before the next rising edge. The
   // model then retires or accepts in step with the handshake.
   task automatic applyStimulus(input logic v, input logic wr, input logic [1:0] sz,
                                input logic uns, input logic [63:0] a, input logic [63:0] d,
                                input logic rr, output logic acc);
      logic exp_valid;
      logic exp_ready;
      exp_t e;
      req_valid = v; req_write = wr; req_size = sz; req_unsigned = uns;
      addr = a; wdata = d; rsp_ready = rr;
      #1;
      exp_valid = (exp_q.size() > 0) &&
                  ((cycle_no - exp_q[0].acc_cycle - (stall_no - exp_q[0].acc_stalls)) >= LAT);
      exp_ready = !exp_valid || rr;
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
      checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
      if (exp_valid) begin
         checkOutput("rsp_data", rsp_data, exp_q[0].data);
         checkOutput("rsp_err", 64'(rsp_err), 64'(exp_q[0].err));
         if (rr) begin
            rsp_log.push_back(rsp_data);
            err_log.push_back(rsp_err);
            void'(exp_q.pop_front());
         end else begin
            stall_no++;
         end
      end
      acc = v && exp_ready;
      if (acc) begin
         refRequest(wr, sz, uns, a, d, e);
         e.acc_cycle  = cycle_no;
         e.acc_stalls = stall_no;
         exp_q.push_back(e);
      end
      @(posedge clk);
      @(negedge clk);
      cycle_no++;
   endtask

   // Present a request with the consumer always ready until it is taken.
   task automatic issue(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [63:0] a, input logic [63:0] d);
      logic acc;
      acc = 1'b0;
      for (int t = 0; t < 20 && !acc; t++) applyStimulus(1'b1, wr, sz, uns, a, d, 1'b1, acc);
      checkOutput("issue_accepted", 64'(acc), 64'd1);
   endtask

   // Idle with the consumer ready until every expected response has retired.
   task automatic drain();
      logic acc;
      for (int t = 0; t < 50 && exp_q.size() > 0; t++)
         applyStimulus(1'b0, 1'b0, 2'd0, 1'b0, 64'd0, 64'd0, 1'b1, acc);
      checkOutput("drain_left", 64'(exp_q.size()), 64'd0);
   endtask

   // One cycle on the 32-bit instance; outputs are read after the next rising edge.
   task automatic stepB(input logic v, input logic wr, input logic [1:0] sz,
                        input logic uns, input logic [63:0] a, input logic [31:0] d);
      req_valid_b = v; req_write_b = wr; req_size_b = sz; req_unsigned_b = uns;
      addr_b = a; wdata_b = d; rsp_ready_b = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Directed sequences followed by a randomized run and the 32-bit checks.
   initial begin
      logic acc;
      logic v, wr, uns, rr;
      logic [1:0] sz;
      logic [63:0] a, d;
      int   idx;
      logic [63:0] bp_addr [6];

      for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
      rst_n = 1'b0;
      req_valid = 0; req_write = 0; req_size = 0; req_unsigned = 0; addr = 0; wdata = 0; rsp_ready = 1;
      req_valid_b = 0; req_write_b = 0; req_size_b = 0; req_unsigned_b = 0; addr_b = 0; wdata_b = 0;
      rsp_ready_b = 1;

      // Outputs during reset.
      @(negedge clk);
      #1;
      checkOutput("reset_valid", 64'(rsp_valid), 64'd0);
      checkOutput("reset_data", rsp_data, 64'd0);
      checkOutput("reset_err", 64'(rsp_err), 64'd0);
      checkOutput("reset_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Sized stores and sign/zero-extended loads.
      $display("[TB] sized stores and loads");
      rsp_log.delete(); err_log.delete();
      issue(1'b1, 2'd3, 1'b0, 64'h08, 64'h8877665544332211);
      issue(1'b1, 2'd0, 1'b0, 64'h09, 64'h00000000000000AA);
      issue(1'b0, 2'd1, 1'b1, 64'h08, 64'd0);
      issue(1'b0, 2'd0, 1'b0, 64'h09, 64'd0);
      issue(1'b0, 2'd2, 1'b0, 64'h0C, 64'd0);
      drain();
      checkOutput("half_unsigned", rsp_log[2], 64'h0000_0000_0000_AA11);
      checkOutput("byte_signed", rsp_log[3], 64'hFFFF_FFFF_FFFF_FFAA);
      checkOutput("word_signed", rsp_log[4], 64'hFFFF_FFFF_8877_6655);

      // Misaligned, beyond the end, and beyond the end via upper address bits.
      $display("[TB] error requests");
      rsp_log.delete(); err_log.delete();
      issue(1'b1, 2'd2, 1'b0, 64'h06, 64'h00000000DEADBEEF);
      issue(1'b0, 2'd3, 1'b0, 64'hFC, 64'd0);
      issue(1'b0, 2'd0, 1'b1, 64'h1_0000_0008, 64'd0);
      issue(1'b0, 2'd3, 1'b0, 64'h00, 64'd0);
      issue(1'b0, 2'd3, 1'b0, 64'h08, 64'd0);
      drain();
      checkOutput("store_mis_err", 64'(err_log[0]), 64'd1);
      checkOutput("load_oor_err", 64'(err_log[1]), 64'd1);
      checkOutput("load_oor_data", rsp_log[1], 64'd0);
      checkOutput("load_high_err", 64'(err_log[2]), 64'd1);
      checkOutput("mem_lo_kept", rsp_log[3], 64'd0);
      checkOutput("mem_hi_kept", rsp_log[4], 64'h8877_6655_4433_AA11);

      // Six back-to-back loads against a toggling consumer.
      $display("[TB] backpressure");
      rsp_log.delete(); err_log.delete();
      bp_addr = '{64'h08, 64'h09, 64'h0A, 64'h0C, 64'h0E, 64'h0F};
      idx = 0;
      for (int c = 0; c < 60 && !(idx == 6 && exp_q.size() == 0); c++) begin
         rr = (c % 6 == 0) || (c % 6 == 3) || (c % 6 == 5);
         sz = (idx == 0) ? 2'd3 : (idx == 2 || idx == 4) ? 2'd1 : (idx == 3) ? 2'd2 : 2'd0;
         applyStimulus(idx < 6, 1'b0, sz, 1'b0, (idx < 6) ? bp_addr[idx] : 64'd0, 64'd0, rr, acc);
         if (acc) idx++;
      end
      checkOutput("bp_accepted", 64'(idx), 64'd6);
      checkOutput("bp_responses", 64'(rsp_log.size()), 64'd6);

      // Store then load in the very next cycle.
      $display("[TB] read after write");
      rsp_log.delete(); err_log.delete();
      issue(1'b1, 2'd1, 1'b0, 64'h20, 64'h1234);
      issue(1'b0, 2'd1, 1'b0, 64'h20, 64'd0);
      drain();
      checkOutput("raw_half", rsp_log[1], 64'h1234);

      // Reset with three loads in flight; memory and pipe must both clear.
      $display("[TB] reset mid-stream");
      issue(1'b1, 2'd0, 1'b0, 64'h10, 64'h5A);
      drain();
      issue(1'b0, 2'd3, 1'b0, 64'h08, 64'd0);
      issue(1'b0, 2'd0, 1'b1, 64'h10, 64'd0);
      issue(1'b0, 2'd3, 1'b0, 64'h18, 64'd0);
      req_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midrst_valid", 64'(rsp_valid), 64'd0);
      checkOutput("midrst_data", rsp_data, 64'd0);
      checkOutput("midrst_err", 64'(rsp_err), 64'd0);
      checkOutput("midrst_ready", 64'(req_ready), 64'd0);
      exp_q.delete();
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'd0;
      @(negedge clk);
      rst_n = 1'b1;
      rsp_log.delete(); err_log.delete();
      issue(1'b0, 2'd0, 1'b1, 64'h10, 64'd0);
      drain();
      checkOutput("postrst_count", 64'(rsp_log.size()), 64'd1);
      checkOutput("postrst_data", rsp_log[0], 64'd0);

      // Randomized traffic, mostly in range and often aligned.
      $display("[TB] random traffic");
      for (int c = 0; c < 400; c++) begin
         v   = ($urandom_range(0, 3) != 0);
         wr  = $urandom_range(0, 1) == 1;
         sz  = 2'($urandom_range(0, 3));
         uns = $urandom_range(0, 1) == 1;
         rr  = ($urandom_range(0, 3) != 0);
         d   = {$urandom, $urandom};
         if ($urandom_range(0, 9) == 0) begin
            a = {$urandom, $urandom};
         end else begin
            a = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~((64'd1 << sz) - 64'd1);
         end
         applyStimulus(v, wr, sz, uns, a, d, rr, acc);
      end
      drain();
      req_valid = 1'b0;

      // 32-bit instance: illegal double size, signed word, read after write.
      $display("[TB] 32-bit instance");
      #1;
      checkOutput("b_ready", 64'(req_ready_b), 64'd1);
      stepB(1'b1, 1'b1, 2'd2, 1'b0, 64'h04, 32'h80000000);
      checkOutput("b_store_valid", 64'(rsp_valid_b), 64'd1);
      checkOutput("b_store_err", 64'(rsp_err_b), 64'd0);
      stepB(1'b1, 1'b0, 2'd2, 1'b0, 64'h04, 32'd0);
      checkOutput("b_word_signed", 64'(rsp_data_b), 64'h80000000);
      stepB(1'b1, 1'b0, 2'd3, 1'b0, 64'h00, 32'd0);
      checkOutput("b_size3_err", 64'(rsp_err_b), 64'd1);
      checkOutput("b_size3_data", 64'(rsp_data_b), 64'd0);
      stepB(1'b1, 1'b1, 2'd1, 1'b0, 64'h20, 32'h1234);
      stepB(1'b1, 1'b0, 2'd1, 1'b1, 64'h20, 32'd0);
      checkOutput("b_raw_half", 64'(rsp_data_b), 64'h1234);
      stepB(1'b0, 1'b0, 2'd0, 1'b0, 64'h00, 32'd0);
      checkOutput("b_idle_valid", 64'(rsp_valid_b), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
